// File: rtl/blink_sched.sv
// blink_sched: two-requester round-robin scheduler for a single LED blink divider.
//
// A requester holds req[i] high for the whole burst. The scheduler grants one
// requester, latches that requester's half-period and toggle count in LOAD, and
// then runs the divide counter in RUN. Every H cycles led_out inverts, until T
// toggles have been issued. DONE then pulses done[owner] for one cycle and
// returns to IDLE. If the owner drops its request in LOAD or RUN, the burst is
// abandoned without a done pulse.
//
// Parameters
//   CNT_W        : divide counter / half-period width
//   TOG_W        : toggle-count width
//   DEFAULT_HALF : half-period substituted when a requester supplies 0
//
// Ports
//   int_osc      in   clock for all logic
//   reset        in   synchronous, active-high reset
//   req[1:0]     in   level-held burst request, one bit per requester
//   half_period0 in   requester 0 half-period (cycles)
//   half_period1 in   requester 1 half-period (cycles)
//   toggles0     in   requester 0 toggle count
//   toggles1     in   requester 1 toggle count
//   gnt[1:0]     out  one-hot grant
//   done[1:0]    out  one-cycle completion pulse to the owner
//   busy         out  high whenever the FSM is not in IDLE
//   led_out      out  LED drive
module blink_sched #(
  parameter int unsigned CNT_W        = 25,
  parameter int unsigned TOG_W        = 8,
  parameter int unsigned DEFAULT_HALF = 10_000_000
) (
  input  logic             int_osc,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] half_period0,
  input  logic [CNT_W-1:0] half_period1,
  input  logic [TOG_W-1:0] toggles0,
  input  logic [TOG_W-1:0] toggles1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             led_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HALF_DEF = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TOG_W-1:0] TOG_ONE  = TOG_W'(1);

  // Registered state
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] half_q;
  logic [TOG_W-1:0] rem_q;
  logic             owner_q;
  logic             last_owner_q;

  // Next-state values
  state_t           state_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] half_d;
  logic [TOG_W-1:0] rem_d;
  logic             owner_d;
  logic             last_owner_d;
  logic [1:0]       gnt_d;
  logic [1:0]       done_d;
  logic             busy_d;
  logic             led_d;

  // Helper decodes
  logic             winner_c;
  logic             owner_req_c;
  logic [1:0]       owner_oh_c;
  logic [CNT_W-1:0] sel_half_c;
  logic [TOG_W-1:0] sel_tog_c;
  logic             wrap_c;

  // Round-robin pick: on a tie the requester that did not own the last burst wins.
  always_comb begin
    winner_c = 1'b0;
    if (req == 2'b11) begin
      winner_c = ~last_owner_q;
    end else if (req[1] && !req[0]) begin
      winner_c = 1'b1;
    end
  end

  // Owner-indexed views of the request and parameter inputs.
  always_comb begin
    owner_req_c = owner_q ? req[1] : req[0];
    owner_oh_c  = owner_q ? 2'b10 : 2'b01;
    sel_half_c  = owner_q ? half_period1 : half_period0;
    sel_tog_c   = owner_q ? toggles1 : toggles0;
    // half_q is never 0 (0 is replaced by DEFAULT_HALF), so H-1 cannot wrap.
    wrap_c      = (cnt_q == (half_q - CNT_ONE));
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    rem_d        = rem_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt;
    done_d       = 2'b00;
    led_d        = led_out;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d = winner_c;
          gnt_d   = winner_c ? 2'b10 : 2'b01;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (!owner_req_c) begin
          // Owner withdrew: abandon silently, still rotate priority.
          state_d      = ST_IDLE;
          gnt_d        = 2'b00;
          led_d        = 1'b0;
          cnt_d        = '0;
          last_owner_d = owner_q;
        end else begin
          half_d = (sel_half_c == '0) ? HALF_DEF : sel_half_c;
          rem_d  = sel_tog_c;
          cnt_d  = '0;
          led_d  = 1'b0;
          if (sel_tog_c == '0) begin
            state_d = ST_DONE;
            done_d  = owner_oh_c;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (!owner_req_c) begin
          state_d      = ST_IDLE;
          gnt_d        = 2'b00;
          led_d        = 1'b0;
          cnt_d        = '0;
          last_owner_d = owner_q;
        end else if (wrap_c) begin
          cnt_d = '0;
          led_d = ~led_out;
          if (rem_q != '0) begin
            rem_d = rem_q - TOG_ONE;
          end
          // Last toggle: the same edge enters DONE and raises done[owner].
          if (rem_q <= TOG_ONE) begin
            state_d = ST_DONE;
            done_d  = owner_oh_c;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        state_d      = ST_IDLE;
        gnt_d        = 2'b00;
        led_d        = 1'b0;
        last_owner_d = owner_q;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
        led_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge int_osc) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      half_q       <= '0;
      rem_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      gnt          <= 2'b00;
      done         <= 2'b00;
      busy         <= 1'b0;
      led_out      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      rem_q        <= rem_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt          <= gnt_d;
      done         <= done_d;
      busy         <= busy_d;
      led_out      <= led_d;
    end
  end

endmodule
